// File: rtl/bicubic_pkg.sv
// bicubic_pkg
// Shared helpers for the bicubic tap-sum stage: internal sum width,
// rounding constant, clamp bounds and pipeline latency.
// No ports; imported by bicubic_tap_sum and bicubic_tap_sum_ch.
package bicubic_pkg;

  // Two extra bits are enough to add four terms without overflow.
  function automatic int sum_width(input int term_w);
    return term_w + 2;
  endfunction

  // Half an output LSB when rounding, zero when truncating.
  function automatic logic [127:0] round_const(input int frac_w, input int round_mode);
    return (round_mode == 1) ? (128'd1 << (frac_w - 1)) : 128'd0;
  endfunction

  // Largest representable unsigned output pixel.
  function automatic logic [127:0] clamp_max(input int out_w);
    return (128'd1 << out_w) - 128'd1;
  endfunction

  localparam logic [127:0] CLAMP_MIN = 128'd0;

  // Three arithmetic stages plus the optional alignment registers.
  function automatic int latency(input int extra_dly);
    return 3 + extra_dly;
  endfunction

  localparam int EXTRA_DLY_DEF = 2;
  localparam int LAT           = latency(EXTRA_DLY_DEF);

endpackage

// File: rtl/bicubic_tap_sum_ch.sv
// bicubic_tap_sum_ch
// Single-channel S1..S3 datapath: pairwise add, final add with rounding
// constant, then arithmetic shift and clamp to the unsigned output range.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   ce                stage enable; low holds every register
//   t0..t3            signed tap terms (TERM_W)
//   out_data          clamped pixel (OUT_W), registered
//   sat_hi / sat_lo   clamp indicators, registered with out_data
module bicubic_tap_sum_ch
  import bicubic_pkg::*;
#(
  parameter int TERM_W     = 40,
  parameter int FRAC_W     = 24,
  parameter int OUT_W      = 9,
  parameter int ROUND_MODE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic [TERM_W-1:0] t0,
  input  logic [TERM_W-1:0] t1,
  input  logic [TERM_W-1:0] t2,
  input  logic [TERM_W-1:0] t3,
  output logic [OUT_W-1:0]  out_data,
  output logic              sat_hi,
  output logic              sat_lo
);

  localparam int SUM_W = sum_width(TERM_W);
  localparam logic [127:0] RC_FULL = round_const(FRAC_W, ROUND_MODE);
  localparam logic [127:0] QMAX_FULL = clamp_max(OUT_W);
  localparam logic signed [SUM_W-1:0] RC    = RC_FULL[SUM_W-1:0];
  localparam logic signed [SUM_W-1:0] Q_MAX = QMAX_FULL[SUM_W-1:0];

  logic signed [SUM_W-1:0] x0, x1, x2, x3;
  logic signed [SUM_W-1:0] p01, p23, s, q;

  assign x0 = {{2{t0[TERM_W-1]}}, t0};
  assign x1 = {{2{t1[TERM_W-1]}}, t1};
  assign x2 = {{2{t2[TERM_W-1]}}, t2};
  assign x3 = {{2{t3[TERM_W-1]}}, t3};

  assign q = s >>> FRAC_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p01      <= '0;
      p23      <= '0;
      s        <= '0;
      out_data <= '0;
      sat_hi   <= 1'b0;
      sat_lo   <= 1'b0;
    end else if (ce) begin
      p01 <= x0 + x1;
      p23 <= x2 + x3;
      s   <= p01 + p23 + RC;
      if (q[SUM_W-1]) begin
        out_data <= '0;
        sat_hi   <= 1'b0;
        sat_lo   <= 1'b1;
      end else if (q > Q_MAX) begin
        out_data <= '1;
        sat_hi   <= 1'b1;
        sat_lo   <= 1'b0;
      end else begin
        out_data <= q[OUT_W-1:0];
        sat_hi   <= 1'b0;
        sat_lo   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bicubic_tap_sum.sv
// bicubic_tap_sum
// Combines four signed pre-weighted tap products per colour channel into a
// clamped unsigned pixel. Owns the valid pipeline, EXTRA_DLY alignment
// registers and, with BICUBIC_TAP_SAT_CNT_EN defined, per-channel
// saturation event counters.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   ce                   pipeline enable; low freezes every stage
//   in_valid             terms valid (sampled when ce=1)
//   term0..term3         NUM_CH*TERM_W signed terms, ch0 in LSBs
//   out_valid            out_data valid
//   out_data             NUM_CH*OUT_W clamped pixels, ch0 in LSBs
//   sat_hi / sat_lo      per-channel clamp flags aligned with out_data
//   cnt_clr, sat_cnt     (BICUBIC_TAP_SAT_CNT_EN only) clear and
//                        NUM_CH*16 saturating event counters
module bicubic_tap_sum
  import bicubic_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int TERM_W     = 40,
  parameter int FRAC_W     = 24,
  parameter int OUT_W      = 9,
  parameter int ROUND_MODE = 1,
  parameter int EXTRA_DLY  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     in_valid,
  input  logic [NUM_CH*TERM_W-1:0] term0,
  input  logic [NUM_CH*TERM_W-1:0] term1,
  input  logic [NUM_CH*TERM_W-1:0] term2,
  input  logic [NUM_CH*TERM_W-1:0] term3,
  output logic                     out_valid,
  output logic [NUM_CH*OUT_W-1:0]  out_data,
  output logic [NUM_CH-1:0]        sat_hi,
  output logic [NUM_CH-1:0]        sat_lo
`ifdef BICUBIC_TAP_SAT_CNT_EN
  ,
  input  logic                     cnt_clr,
  output logic [NUM_CH*16-1:0]     sat_cnt
`endif
);

  localparam int LAT_I = latency(EXTRA_DLY);

  logic [LAT_I-1:0]        vpipe;
  logic [NUM_CH*OUT_W-1:0] s3_data;
  logic [NUM_CH-1:0]       s3_hi, s3_lo;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    bicubic_tap_sum_ch #(
      .TERM_W    (TERM_W),
      .FRAC_W    (FRAC_W),
      .OUT_W     (OUT_W),
      .ROUND_MODE(ROUND_MODE)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .ce      (ce),
      .t0      (term0[c*TERM_W +: TERM_W]),
      .t1      (term1[c*TERM_W +: TERM_W]),
      .t2      (term2[c*TERM_W +: TERM_W]),
      .t3      (term3[c*TERM_W +: TERM_W]),
      .out_data(s3_data[c*OUT_W +: OUT_W]),
      .sat_hi  (s3_hi[c]),
      .sat_lo  (s3_lo[c])
    );
  end

  // Valid travels alongside the data; data stages load regardless of valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else if (ce) begin
      vpipe <= {vpipe[LAT_I-2:0], in_valid};
    end
  end

  assign out_valid = vpipe[LAT_I-1];

  if (EXTRA_DLY == 0) begin : g_nodly
    assign out_data = s3_data;
    assign sat_hi   = s3_hi;
    assign sat_lo   = s3_lo;
  end else begin : g_dly
    logic [NUM_CH*OUT_W-1:0] dly_d  [EXTRA_DLY];
    logic [NUM_CH-1:0]       dly_hi [EXTRA_DLY];
    logic [NUM_CH-1:0]       dly_lo [EXTRA_DLY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < EXTRA_DLY; i++) begin
          dly_d[i]  <= '0;
          dly_hi[i] <= '0;
          dly_lo[i] <= '0;
        end
      end else if (ce) begin
        dly_d[0]  <= s3_data;
        dly_hi[0] <= s3_hi;
        dly_lo[0] <= s3_lo;
        for (int i = 1; i < EXTRA_DLY; i++) begin
          dly_d[i]  <= dly_d[i-1];
          dly_hi[i] <= dly_hi[i-1];
          dly_lo[i] <= dly_lo[i-1];
        end
      end
    end

    assign out_data = dly_d[EXTRA_DLY-1];
    assign sat_hi   = dly_hi[EXTRA_DLY-1];
    assign sat_lo   = dly_lo[EXTRA_DLY-1];
  end

`ifdef BICUBIC_TAP_SAT_CNT_EN
  // Clear wins over any increment in the same cycle; counters stick at 0xFFFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (cnt_clr) begin
      sat_cnt <= '0;
    end else if (ce && out_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ((sat_hi[c] || sat_lo[c]) && (sat_cnt[c*16 +: 16] != 16'hFFFF)) begin
          sat_cnt[c*16 +: 16] <= sat_cnt[c*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule
